ppu_vram_arbiter: RTL and testbench

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

---
 rtl/ppu_vram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// rtl/ppu_vram_arbiter.sv - PPU VRAM arbiter: rendering fetches with strict priority over one buffered CPU access.
// Optional starvation guard enabled by defining PPU_ARB_STARVE_GUARD_EN.
module ppu_vram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren_req,
    input  logic [13:0] ren_addr,
    output logic        ren_gnt,
    output logic        ren_rvalid,
    output logic [7:0]  ren_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    output logic        vram_en,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        starve_evt
);

    typedef enum logic [1:0] {IDLE, PEND, RD_WAIT} state_t;

    state_t      state, state_nxt;
    logic        buf_we;
    logic [13:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic [13:0] addr_q;
    logic [7:0]  wdata_q;
    logic        rd_q;
    logic        own_cpu_q;
    logic [7:0]  ren_rdata_q;
    logic [7:0]  cpu_rdata_q;
    logic        force_slot;
    logic        accept;
    logic        ren_issue;
    logic        cpu_issue;

`ifdef PPU_ARB_STARVE_GUARD_EN
    logic [5:0] starve_cnt;
    logic       force_q;

    // force_q arms one cycle after the counter hits 63, stealing exactly one slot from rendering
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 6'd0;
            force_q    <= 1'b0;
        end else begin
            starve_cnt <= (state == PEND && !cpu_issue) ? starve_cnt + 6'd1 : 6'd0;
            force_q    <= (state == PEND) && !cpu_issue && (starve_cnt == 6'd63);
        end
    end

    assign force_slot = force_q;
`else
    assign force_slot = 1'b0;
`endif

    assign accept    = cpu_req && (state == IDLE) && !rst;
    assign ren_issue = ren_req && !rst && !force_slot;
    assign cpu_issue = (state == PEND) && !rst && (!ren_req || force_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ren_gnt    = 1'b0;
        cpu_busy   = 1'b0;
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = addr_q;
        vram_wdata = wdata_q;
        ren_rvalid = 1'b0;
        cpu_rvalid = 1'b0;
        ren_rdata  = ren_rdata_q;
        cpu_rdata  = cpu_rdata_q;
        starve_evt = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = PEND;
            PEND:    if (cpu_issue) state_nxt = buf_we ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            ren_gnt    = ren_issue;
            cpu_busy   = (state != IDLE);
            vram_en    = ren_issue || cpu_issue;
            vram_we    = cpu_issue && buf_we;
            starve_evt = force_slot && cpu_issue;
            if (ren_issue) begin
                vram_addr = ren_addr;
            end else if (cpu_issue) begin
                vram_addr = buf_addr;
            end
            if (cpu_issue && buf_we) begin
                vram_wdata = buf_wdata;
            end
            ren_rvalid = rd_q && !own_cpu_q;
            cpu_rvalid = rd_q && own_cpu_q;
            // Read data is passed straight through in the rvalid cycle, then held from the register
            if (ren_rvalid) ren_rdata = vram_rdata;
            if (cpu_rvalid) cpu_rdata = vram_rdata;
        end else begin
            vram_addr  = 14'd0;
            vram_wdata = 8'd0;
            ren_rdata  = 8'd0;
            cpu_rdata  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_we      <= 1'b0;
            buf_addr    <= 14'd0;
            buf_wdata   <= 8'd0;
            addr_q      <= 14'd0;
            wdata_q     <= 8'd0;
            rd_q        <= 1'b0;
            own_cpu_q   <= 1'b0;
            ren_rdata_q <= 8'd0;
            cpu_rdata_q <= 8'd0;
        end else begin
            if (accept) begin
                buf_we    <= cpu_we;
                buf_addr  <= cpu_addr;
                buf_wdata <= cpu_wdata;
            end
            if (vram_en) addr_q <= vram_addr;
            if (vram_we) wdata_q <= vram_wdata;
            rd_q      <= vram_en && !vram_we;
            own_cpu_q <= cpu_issue;
            if (ren_rvalid) ren_rdata_q <= vram_rdata;
            if (cpu_rvalid) cpu_rdata_q <= vram_rdata;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb/tb_ppu_vram_arbiter.sv - scoreboard bench for ppu_vram_arbiter with a behavioural VRAM.
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren_req;
    logic [13:0] ren_addr;
    logic        ren_gnt;
    logic        ren_rvalid;
    logic [7:0]  ren_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vram_en;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        starve_evt;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } acc_t;

    acc_t       vq[$];
    logic [7:0] rq[$];
    logic [7:0] cq[$];
    logic [7:0] mem [0:16383];
    int         total = 0;
    int         bad = 0;

    ppu_vram_arbiter dut (
        .clk(clk), .rst(rst),
        .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt),
        .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .starve_evt(starve_evt)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata <= mem[vram_addr];
        end
    end

    // Monitor: every VRAM strobe and rvalid must match the next queued expectation
    always @(negedge clk) begin
        acc_t       e;
        logic [7:0] d;
        if (vram_en) begin
            total++;
            if (vq.size() == 0) begin
                bad++;
                $display("FAIL vram_unexpected: got we=%0b addr=%h wdata=%h, expected no access", vram_we, vram_addr, vram_wdata);
            end else begin
                e = vq.pop_front();
                if (vram_we !== e.we || vram_addr !== e.addr || (e.we && vram_wdata !== e.wdata)) begin
                    bad++;
                    $display("FAIL vram_access: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                             vram_we, vram_addr, vram_wdata, e.we, e.addr, e.wdata);
                end
            end
        end
        if (ren_rvalid) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL ren_rvalid_unexpected: got rdata=%h, expected no pulse", ren_rdata);
            end else begin
                d = rq.pop_front();
                if (ren_rdata !== d) begin
                    bad++;
                    $display("FAIL ren_rdata: got %h, expected %h", ren_rdata, d);
                end
            end
        end
        if (cpu_rvalid) begin
            total++;
            if (cq.size() == 0) begin
                bad++;
                $display("FAIL cpu_rvalid_unexpected: got rdata=%h, expected no pulse", cpu_rdata);
            end else begin
                d = cq.pop_front();
                if (cpu_rdata !== d) begin
                    bad++;
                    $display("FAIL cpu_rdata: got %h, expected %h", cpu_rdata, d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [13:0] a, input logic [7:0] d);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic ren_read(input logic [13:0] a, input logic [7:0] d, input logic expect_rvalid);
        ren_req  = 1'b1;
        ren_addr = a;
        vq.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
        if (expect_rvalid) rq.push_back(d);
    endtask

    task automatic cpu_read(input logic [13:0] a, input logic [7:0] d);
        set_cpu(1'b1, 1'b0, a, 8'h00);
        vq.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
        cq.push_back(d);
        @(negedge clk);
        chk("rd_busy_accept", cpu_busy, 0);
        cyc();
        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
        @(negedge clk);
        chk("rd_busy_issue", cpu_busy, 1);
        chk("rd_issue_en", vram_en, 1);
        cyc();
        @(negedge clk);
        chk("rd_rvalid", cpu_rvalid, 1);
        cyc();
        @(negedge clk);
        chk("rd_busy_done", cpu_busy, 0);
        chk("rd_hold", cpu_rdata, d);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[14'h0100 + i] = 8'h10 + 8'(i);
        mem[14'h23C0] = 8'hA5;
        vram_rdata = 8'h00;

        // Reset with requests present: everything must stay quiet
        rst = 1'b1;
        ren_req = 1'b1;
        ren_addr = 14'h0123;
        set_cpu(1'b1, 1'b1, 14'h1111, 8'hEE);
        cyc();
        @(negedge clk);
        chk("rst_ren_gnt", ren_gnt, 0);
        chk("rst_vram_en", vram_en, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_rdata", {cpu_rdata, ren_rdata}, 0);
        cyc();
        rst = 1'b0;
        ren_req = 1'b0;
        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
        @(negedge clk);
        chk("idle_vram_en", vram_en, 0);
        chk("idle_busy", cpu_busy, 0);
        cyc();

        // Idle-bus CPU write
        set_cpu(1'b1, 1'b1, 14'h2005, 8'h3C);
        vq.push_back('{we: 1'b1, addr: 14'h2005, wdata: 8'h3C});
        @(negedge clk);
        chk("wr_busy_accept", cpu_busy, 0);
        cyc();
        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
        @(negedge clk);
        chk("wr_busy_issue", cpu_busy, 1);
        chk("wr_issue_we", {vram_en, vram_we}, 2'b11);
        cyc();
        @(negedge clk);
        chk("wr_busy_done", cpu_busy, 0);
        chk("wr_addr_hold", vram_addr, 14'h2005);
        cyc();

        cpu_read(14'h23C0, 8'hA5);
        cpu_read(14'h2005, 8'h3C);

        // Rendering burst of 8 with CPU write accepted in cycle 2
        for (int k = 0; k < 8; k++) begin
            ren_read(14'h0100 + 14'(k), 8'h10 + 8'(k), 1'b1);
            if (k == 1) set_cpu(1'b1, 1'b1, 14'h3F00, 8'h21);
            else        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
            @(negedge clk);
            chk("burst_gnt", ren_gnt, 1);
            if (k >= 2) chk("burst_busy", cpu_busy, 1);
            cyc();
        end
        ren_req = 1'b0;
        vq.push_back('{we: 1'b1, addr: 14'h3F00, wdata: 8'h21});
        @(negedge clk);
        chk("burst_cpu_issue", vram_we, 1);
        chk("burst_gnt_low", ren_gnt, 0);
        cyc();
        @(negedge clk);
        chk("burst_busy_done", cpu_busy, 0);
        chk("ren_rdata_hold", ren_rdata, 8'h17);
        cyc();

        // Second request while busy must be dropped
        ren_read(14'h0102, 8'h12, 1'b1);
        set_cpu(1'b1, 1'b1, 14'h2006, 8'h11);
        cyc();
        ren_read(14'h0103, 8'h13, 1'b1);
        set_cpu(1'b1, 1'b1, 14'h2100, 8'h55);
        @(negedge clk);
        chk("drop_busy", cpu_busy, 1);
        cyc();
        ren_read(14'h0104, 8'h14, 1'b1);
        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
        cyc();
        ren_req = 1'b0;
        vq.push_back('{we: 1'b1, addr: 14'h2006, wdata: 8'h11});
        cyc();
        @(negedge clk);
        chk("drop_idle", cpu_busy, 0);
        cyc();
        cpu_read(14'h2100, 8'h00);

        // Reset while a CPU write is pending and a rendering read is in flight
        ren_read(14'h0101, 8'h11, 1'b0);
        set_cpu(1'b1, 1'b1, 14'h2200, 8'h77);
        cyc();
        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", ren_gnt, 0);
        chk("midrst_rvalid", ren_rvalid, 0);
        cyc();
        rst = 1'b0;
        ren_req = 1'b0;
        @(negedge clk);
        chk("midrst_busy", cpu_busy, 0);
        chk("midrst_en", vram_en, 0);
        cyc();
        @(negedge clk);
        chk("midrst_en2", vram_en, 0);
        cyc();
        cpu_read(14'h2200, 8'h00);

        // Long rendering stream with a CPU write pending
        for (int k = 0; k < 70; k++) begin
            if (k == 0) set_cpu(1'b1, 1'b1, 14'h2300, 8'h99);
            else        set_cpu(1'b0, 1'b0, 14'h0, 8'h00);
`ifdef PPU_ARB_STARVE_GUARD_EN
            if (k == 65) begin
                ren_req  = 1'b1;
                ren_addr = 14'h0100 + 14'(k % 8);
                vq.push_back('{we: 1'b1, addr: 14'h2300, wdata: 8'h99});
                @(negedge clk);
                chk("starve_gnt", ren_gnt, 0);
                chk("starve_evt", starve_evt, 1);
            end else begin
                ren_read(14'h0100 + 14'(k % 8), 8'h10 + 8'(k % 8), 1'b1);
                @(negedge clk);
                chk("long_gnt", ren_gnt, 1);
                chk("long_starve", starve_evt, 0);
            end
`else
            ren_read(14'h0100 + 14'(k % 8), 8'h10 + 8'(k % 8), 1'b1);
            @(negedge clk);
            chk("long_gnt", ren_gnt, 1);
            chk("long_starve", starve_evt, 0);
            if (k > 0) chk("long_busy", cpu_busy, 1);
`endif
            cyc();
        end
        ren_req = 1'b0;
`ifndef PPU_ARB_STARVE_GUARD_EN
        vq.push_back('{we: 1'b1, addr: 14'h2300, wdata: 8'h99});
        @(negedge clk);
        chk("long_cpu_issue", vram_we, 1);
`endif
        cyc();
        cyc();
        cpu_read(14'h2300, 8'h99);
        cyc();

        chk("vq_empty", vq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("cq_empty", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
